// File: rtl/channel_permute_pkg.sv
// Shared lane-transform definitions for the channel permute pipeline.
package channel_permute_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_REV  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_ZERO = 2'b11;

  // One output bit of a lane; a_mirror is the input bit at the reflected position.
  function automatic logic lane_bit(input logic [1:0] mode, input logic a, input logic a_mirror);
    logic b;
    case (mode)
      MODE_PASS: b = a;
      MODE_REV:  b = a_mirror;
      MODE_INV:  b = ~a;
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/channel_permute_stage.sv
// One valid/ready register slice; loads whenever empty or draining downstream.
module channel_permute_stage #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (up_ready && up_valid) begin
      dn_data <= up_data;
    end
  end

endmodule

// File: rtl/channel_permute_pipe.sv
// Per-channel pass/reverse/invert/zero transform feeding a STAGES-deep
// valid/ready pipeline, with a count of delivered output beats.
module channel_permute_pipe
  import channel_permute_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [2*CHANNELS-1:0]     in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          beat_count
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  logic [DW-1:0]   xf_data;
  logic [STAGES:0] vld;
  logic [DW-1:0]   dat [STAGES+1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign xf_data[c*WIDTH+i] = lane_bit(in_mode[2*c +: 2],
                                           in_data[c*WIDTH+i],
                                           in_data[c*WIDTH+WIDTH-1-i]);
    end
  end

  assign vld[0] = in_valid;
  assign dat[0] = xf_data;

  // Ready chain uses a distinct net per slice so each link is a separate signal.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic rdy_up;
    logic rdy_dn;

    if (k == STAGES - 1) begin : g_last
      assign rdy_dn = out_ready;
    end else begin : g_mid
      assign rdy_dn = g_slice[k+1].rdy_up;
    end

    channel_permute_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k]),
      .up_ready (rdy_up),
      .up_data  (dat[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy_dn),
      .dn_data  (dat[k+1])
    );
  end

  assign in_ready  = g_slice[0].rdy_up;
  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (out_valid && out_ready) begin
      beat_count <= beat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_channel_permute_pipe.sv
// Directed bench for channel_permute_pipe: latency, mode sweep, backpressure,
// mid-stream reset, counter wrap and a random valid/ready stream.
module tb_channel_permute_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid;
  logic       in_ready, w_in_ready;
  logic [8:0] in_data;
  logic [5:0] in_mode;
  logic       out_valid, w_out_valid;
  logic       out_ready;
  logic [8:0] out_data, w_out_data;
  logic [15:0] beat_count;
  logic [3:0]  w_beat_count;

  int vectors = 0;
  int miscompares = 0;
  int n_acc = 0;
  int n_deliv = 0;
  int cyc;
  logic [8:0] sb [$];
  logic [2:0] sweep_exp [4];

  always #5 clk = ~clk;

  channel_permute_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .beat_count(beat_count)
  );

  channel_permute_pipe #(.CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .beat_count(w_beat_count)
  );

  function automatic logic [8:0] model(input logic [8:0] d, input logic [5:0] m);
    logic [8:0] r;
    logic [2:0] a;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      a = d[c*3 +: 3];
      case (m[c*2 +: 2])
        2'b00:   r[c*3 +: 3] = a;
        2'b01:   r[c*3 +: 3] = {a[0], a[1], a[2]};
        2'b10:   r[c*3 +: 3] = ~a;
        default: r[c*3 +: 3] = 3'b000;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       acc, dlv;
    logic [8:0] od, ex, ex_d;
    @(negedge clk);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    od  = out_data;
    ex  = model(in_data, in_mode);
    @(posedge clk);
    #1;
    if (dlv) begin
      n_deliv++;
      ex_d = (sb.size() > 0) ? sb.pop_front() : 9'bx;
      check("sb_order", 32'(od), 32'(ex_d));
    end
    if (acc) begin
      sb.push_back(ex);
      n_acc++;
    end
  endtask

  initial begin
    sweep_exp = '{3'b011, 3'b110, 3'b100, 3'b000};
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(beat_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency and basic transform
    in_valid = 1'b1;
    in_data  = 9'b110_011_001;
    in_mode  = 6'b10_00_01;
    tick();
    in_valid = 1'b0;
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'(9'b001_011_100));
    tick();
    check("basic_count", 32'(beat_count), 32'd1);

    // Mode sweep on lane 0
    in_data = 9'b000_000_011;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_mode  = 6'(i % 4);
      tick();
      if (i >= 1 && i <= 4) begin
        check("sweep_valid", 32'(out_valid), 32'd1);
        check("sweep_lane0", 32'(out_data[2:0]), 32'(sweep_exp[i-1]));
      end
      if (i == 5) check("sweep_empty", 32'(out_valid), 32'd0);
    end

    // Backpressure: A, B fill the pipe, C waits at the producer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'b101_010_111;  in_mode = 6'b00_01_10;
    tick();
    check("bp_ready_one", 32'(in_ready), 32'd1);
    in_data   = 9'b001_100_110;  in_mode = 6'b01_11_00;
    tick();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    in_data   = 9'b111_000_011;  in_mode = 6'b10_10_01;
    tick();
    tick();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'h150);
    out_ready = 1'b1;
    #1;
    check("drain_fill_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_b_data", 32'(out_data), 32'h106);
    tick();
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c_data", 32'(out_data), 32'h03E);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Mid-stream reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = '0;
    in_data   = 9'h0F0;
    tick();
    in_data   = 9'h00F;
    tick();
    in_valid  = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(beat_count), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    n_deliv = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'b010_101_100;
    in_mode   = 6'b11_01_00;
    tick();
    in_valid = 1'b0;
    check("post_reset_no_stale", 32'(out_valid), 32'd0);
    tick();
    check("post_reset_valid", 32'(out_valid), 32'd1);
    check("post_reset_data", 32'(out_data), 32'h02C);
    tick();
    check("post_reset_count", 32'(beat_count), 32'd1);

    // Counter wrap: 16 more handshakes, 17 total
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 9'($urandom);
      in_mode = 6'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("wrap_count16", 32'(beat_count), 32'd17);
    check("wrap_count4", 32'(w_beat_count), 32'd1);

    // Random valid/ready stream of 1000 beats from a clean reset
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_deliv = 0;
    n_acc   = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 9'($urandom);
      in_mode   = 6'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((sb.size() > 0 || out_valid) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rand_accepts", 32'(n_acc), 32'd1000);
    check("rand_drained", 32'(sb.size()), 32'd0);
    check("rand_count", 32'(beat_count), 32'd1000);
    check("rand_count_wrap", 32'(w_beat_count), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
